// File: rtl/accl_pair_sched.sv
// Issue scheduler for getAccl: walks all ordered body pairs, one per cycle, with a LATENCY-deep pair tag.
// Latency: pair (i,j) on x1..m2 at cycle 5+i(n+2)+j; its tag on acc_* LATENCY cycles later; no backpressure.
module accl_pair_sched #(
  parameter int NMAX    = 64,
  parameter int IDX_W   = 6,
  parameter int LATENCY = 122
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W:0]   n_bodies,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] rd_addr,
  input  logic [63:0]      rd_x,
  input  logic [63:0]      rd_y,
  input  logic [63:0]      rd_m,
  output logic [63:0]      x1,
  output logic [63:0]      y1,
  output logic [63:0]      z1,
  output logic [63:0]      x2,
  output logic [63:0]      y2,
  output logic [63:0]      m2,
  output logic             acc_valid,
  output logic [IDX_W-1:0] acc_i,
  output logic [IDX_W-1:0] acc_j,
  output logic             acc_last
);

  typedef enum logic [2:0] {IDLE, FETCH_I, LOAD_I, STREAM, DRAIN, DONE} state_t;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] j;
    logic             last;
  } tag_t;

  localparam int               CNT_W     = $clog2(LATENCY + 2);
  localparam logic [IDX_W:0]   N_MAX     = (IDX_W+1)'(NMAX);
  localparam logic [IDX_W:0]   N_ONE     = (IDX_W+1)'(1);
  localparam logic [IDX_W:0]   N_TWO     = (IDX_W+1)'(2);
  localparam logic [CNT_W-1:0] DRAIN_LEN = CNT_W'(LATENCY + 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d, j_q, j_d;
  logic [IDX_W:0]   n_q, n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [63:0]      cx_q, cx_d, cy_q, cy_d;
  logic             s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
  logic [IDX_W-1:0] s1_i_q, s1_i_d, s1_j_q, s1_j_d;
  logic [63:0]      x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d, m2_q, m2_d;
  tag_t             tag_q, tag_d;
  tag_t             dline_q [LATENCY];
  tag_t             dline_d [LATENCY];

  logic             start_ok;
  logic             row_end, last_row;
  logic [IDX_W:0]   last_j;

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    done_d    = 1'b0;

    start_ok  = start && (n_bodies >= N_TWO) && (n_bodies <= N_MAX);
    row_end   = ({1'b0, j_q} == n_q - N_ONE);
    last_row  = ({1'b0, i_q} == n_q - N_ONE);
    last_j    = last_row ? (n_q - N_TWO) : (n_q - N_ONE);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_ok) begin
            state_d = FETCH_I;
            n_d     = n_bodies;
            i_d     = '0;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      FETCH_I: state_d = LOAD_I;
      LOAD_I: begin
        cx_d    = rd_x;
        cy_d    = rd_y;
        j_d     = '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (row_end) begin
          if (last_row) begin
            state_d = DRAIN;
            cnt_d   = DRAIN_LEN;
          end else begin
            i_d     = i_q + 1'b1;
            state_d = FETCH_I;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DRAIN: begin
        // Counts out the last slot's trip through the issue stage and the tag line.
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    done_d = done_d | (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // Read-data stage: remembers which pair the RAM is returning this cycle.
  always_comb begin
    s1_vld_d  = (state_q == STREAM);
    s1_i_d    = i_q;
    s1_j_d    = j_q;
    s1_last_d = ({1'b0, j_q} == last_j);
  end

  // Issue stage: the cache still holds the old row when a row's last pair is registered.
  always_comb begin
    x1_d  = x1_q;
    y1_d  = y1_q;
    x2_d  = x2_q;
    y2_d  = y2_q;
    m2_d  = m2_q;
    tag_d = '0;
    if (s1_vld_q) begin
      x1_d      = cx_q;
      y1_d      = cy_q;
      x2_d      = rd_x;
      y2_d      = rd_y;
      m2_d      = (s1_i_q == s1_j_q) ? 64'h0 : rd_m;
      tag_d.vld = (s1_i_q != s1_j_q);
      tag_d.i   = s1_i_q;
      tag_d.j   = s1_j_q;
      tag_d.last = s1_last_q && (s1_i_q != s1_j_q);
    end
  end

  always_comb begin
    dline_d[0] = tag_q;
    for (int k = 1; k < LATENCY; k++) dline_d[k] = dline_q[k-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      n_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cx_q      <= '0;
      cy_q      <= '0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_i_q    <= '0;
      s1_j_q    <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      x2_q      <= '0;
      y2_q      <= '0;
      m2_q      <= '0;
      tag_q     <= '0;
      for (int k = 0; k < LATENCY; k++) dline_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      s1_vld_q  <= s1_vld_d;
      s1_last_q <= s1_last_d;
      s1_i_q    <= s1_i_d;
      s1_j_q    <= s1_j_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      x2_q      <= x2_d;
      y2_q      <= y2_d;
      m2_q      <= m2_d;
      tag_q     <= tag_d;
      for (int k = 0; k < LATENCY; k++) dline_q[k] <= dline_d[k];
    end
  end

  assign rd_addr   = (state_q == STREAM) ? j_q : i_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign x1        = x1_q;
  assign y1        = y1_q;
  assign z1        = 64'h0;
  assign x2        = x2_q;
  assign y2        = y2_q;
  assign m2        = m2_q;
  assign acc_valid = dline_q[LATENCY-1].vld;
  assign acc_i     = dline_q[LATENCY-1].i;
  assign acc_j     = dline_q[LATENCY-1].j;
  assign acc_last  = dline_q[LATENCY-1].last;

endmodule
